dmem_responder: RTL and testbench

- Memory-side responder for the processor's load/store port: accepts one request at a time over a valid/ready handshake.
- Models WAIT_STATES cycles of access latency, then returns a one-cycle response.
- Performs little-endian byte/half/word lane selection and reports misaligned or illegal-size accesses as errors.
- Sits between the datapath's memory stage (initiator) and word-organised storage; includes a combinational peek port for debug and benches.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed access
// latency, little-endian lane selection, alignment checking and a
// combinational debug peek port into the word-organised storage.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    input  logic [ADDR_W-3:0] peek_addr,
    output logic [31:0]       peek_data
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       cur_word;
    logic              access_err;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;
    logic              mem_we;

    // Decode the latched request against the addressed word: error check,
    // right-aligned load lane and the store word with only its lane(s) replaced.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_idx    = addr_q[ADDR_W-1:2];
        cur_word    = mem_q[word_idx];
        access_err  = (size_q == 2'b11)
                    | ((size_q == SIZE_HALF) & addr_q[0])
                    | ((size_q == SIZE_WORD) & (addr_q[1:0] != 2'b00));
        load_data   = '0;
        merged_word = cur_word;
        unique case (size_q)
            SIZE_BYTE: begin
                load_data[7:0] = cur_word[{addr_q[1:0], 3'b000} +: 8];
                merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SIZE_HALF: begin
                load_data[15:0] = cur_word[{addr_q[1], 4'b0000} +: 16];
                merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            SIZE_WORD: begin
                load_data   = cur_word;
                merged_word = wdata_q;
            end
            default: begin
                load_data   = '0;
                merged_word = cur_word;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, count down in WAIT, access on the
    // last WAIT edge and present the response for the single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = write_q & ~access_err;
                    rdata_d = (write_q | access_err) ? 32'd0 : load_data;
                    err_d   = access_err;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; reset wins over any pending access.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Word storage: cleared by reset, otherwise written on the access edge.
    always_ff @(posedge clk) begin
        // NOTE: storage must come up as all-zero after reset, so the array is
        // cleared explicitly; this costs a reset path on every word.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    assign req_ready  = (state_q == S_IDLE) & ~reset;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != S_IDLE);
    assign peek_data  = mem_q[peek_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-level model (latency arithmetic plus
// a word array updated with shift/mask lane math) is compared against the DUT
// every cycle, with literal expectations for the directed scenarios.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int WS     = 2;
    localparam int DEPTH  = 2 ** (ADDR_W - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              req_valid, req_ready, req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_err, busy;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-3:0] peek_addr;
    logic [31:0]       peek_data;

    // Second instance built with zero wait states.
    logic              z_req_valid, z_req_ready, z_req_write;
    logic [1:0]        z_req_size;
    logic [ADDR_W-1:0] z_req_addr;
    logic [31:0]       z_req_wdata;
    logic              z_resp_valid, z_resp_err, z_busy;
    logic [31:0]       z_resp_rdata;
    logic [ADDR_W-3:0] z_peek_addr;
    logic [31:0]       z_peek_data;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .peek_addr(peek_addr), .peek_data(peek_data)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_size(z_req_size), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .busy(z_busy), .peek_addr(z_peek_addr), .peek_data(z_peek_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit              wr;
        logic [1:0]      size;
        logic [ADDR_W-1:0] addr;
        logic [31:0]     wdata;
    } req_t;

    int          cyc = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_idle  = 1'b1;
    bit          m_pend  = 1'b0;
    bit          m_rv    = 1'b0;
    bit          started = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;
    int          m_acc_edge;
    req_t        m_req;

    task automatic model_access();
        int          idx;
        int          lane;
        int          nbytes;
        logic [31:0] w;
        logic [31:0] mask;
        bit          bad;
        idx    = int'(m_req.addr) / 4;
        lane   = int'(m_req.addr) % 4;
        w      = m_mem[idx];
        bad    = (m_req.size == 2'd3) || (m_req.size == 2'd1 && (lane % 2) != 0)
              || (m_req.size == 2'd2 && lane != 0);
        m_err  = bad;
        m_rdata = '0;
        if (!bad) begin
            nbytes = 1 << m_req.size;
            mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (m_req.wr)
                m_mem[idx] = (w & ~(mask << (8 * lane))) | ((m_req.wdata & mask) << (8 * lane));
            else
                m_rdata = (w >> (8 * lane)) & mask;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_idle = 1'b1; m_pend = 1'b0; m_rv = 1'b0;
            m_rdata = '0; m_err = 1'b0; started = 1'b1;
        end else if (m_rv) begin
            m_rv = 1'b0; m_rdata = '0; m_err = 1'b0; m_idle = 1'b1;
        end else if (m_pend) begin
            if (cyc == m_acc_edge) begin
                model_access();
                m_pend = 1'b0;
                m_rv   = 1'b1;
            end
        end else if (m_idle && req_valid) begin
            m_req      = '{wr: req_write, size: req_size, addr: req_addr, wdata: req_wdata};
            m_pend     = 1'b1;
            m_idle     = 1'b0;
            m_acc_edge = cyc + WS + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("req_ready",  {31'd0, req_ready},  {31'd0, m_idle && !reset});
            check("busy",       {31'd0, busy},       {31'd0, !m_idle});
            check("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_err",   {31'd0, resp_err},   {31'd0, m_err});
            check("peek_model", peek_data, m_mem[peek_addr]);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    bit          er;
    int          lat;
    int          acc [4];

    task automatic issue(input bit wr, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, output logic [31:0] r, output bit e,
                         output int l);
        int t;
        int k;
        req_write = wr; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        k = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = ADDR_W'($urandom); req_wdata = $urandom;
        l = -1; r = '1; e = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                l = cyc - k; r = resp_rdata; e = resp_err;
                break;
            end
        end
    endtask

    task automatic peek_check(input string name, input logic [ADDR_W-3:0] idx, input logic [31:0] exp);
        peek_addr = idx;
        #1;
        check(name, peek_data, exp);
    endtask

    task automatic z_issue(input bit wr, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd, output logic [31:0] r, output bit e,
                           output int l);
        int t;
        int k;
        z_req_write = wr; z_req_size = sz; z_req_addr = a; z_req_wdata = wd; z_req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!z_req_ready && t < 50) begin @(negedge clk); t++; end
        if (!z_req_ready) check("z_accept_timeout", {31'd0, z_req_ready}, 32'd1);
        @(posedge clk); #1;
        k = cyc;
        z_req_valid = 1'b0;
        z_req_addr = ADDR_W'($urandom); z_req_wdata = $urandom;
        l = -1; r = '1; e = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (z_resp_valid) begin
                l = cyc - k; r = z_resp_rdata; e = z_resp_err;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0; peek_addr = 0;
        z_req_valid = 0; z_req_write = 0; z_req_size = 0; z_req_addr = 0; z_req_wdata = 0;
        z_peek_addr = 8'hFF;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        peek_check("rst_peek", 8'd4, 32'd0);

        // 1: word store / load
        issue(1'b1, 2'b10, 10'h010, 32'hDEAD_BEEF, rd, er, lat);
        check("t1_st_lat", lat, WS + 1);
        check("t1_st_rdata", rd, 32'd0);
        check("t1_st_err", {31'd0, er}, 32'd0);
        issue(1'b0, 2'b10, 10'h010, 32'd0, rd, er, lat);
        check("t1_ld_lat", lat, WS + 1);
        check("t1_ld_rdata", rd, 32'hDEAD_BEEF);
        check("t1_ld_err", {31'd0, er}, 32'd0);
        peek_check("t1_peek", 8'd4, 32'hDEAD_BEEF);

        // 2: lane stores and loads
        issue(1'b1, 2'b10, 10'h020, 32'h1122_3344, rd, er, lat);
        issue(1'b1, 2'b00, 10'h021, 32'hFFFF_FFAA, rd, er, lat);
        peek_check("t2_byte_st", 8'd8, 32'h1122_AA44);
        issue(1'b1, 2'b01, 10'h022, 32'h1234_BEEF, rd, er, lat);
        peek_check("t2_half_st", 8'd8, 32'hBEEF_AA44);
        issue(1'b0, 2'b00, 10'h023, 32'd0, rd, er, lat);
        check("t2_byte_ld", rd, 32'h0000_00BE);
        issue(1'b0, 2'b01, 10'h020, 32'd0, rd, er, lat);
        check("t2_half_ld", rd, 32'h0000_AA44);

        // 3: error cases
        issue(1'b1, 2'b10, 10'h030, 32'h5555_AAAA, rd, er, lat);
        issue(1'b1, 2'b01, 10'h031, 32'h0000_FFFF, rd, er, lat);
        check("t3_half_mis_err", {31'd0, er}, 32'd1);
        check("t3_half_mis_rdata", rd, 32'd0);
        check("t3_err_lat", lat, WS + 1);
        issue(1'b0, 2'b10, 10'h032, 32'd0, rd, er, lat);
        check("t3_word_mis_err", {31'd0, er}, 32'd1);
        check("t3_word_mis_rdata", rd, 32'd0);
        issue(1'b1, 2'b11, 10'h030, 32'hFFFF_FFFF, rd, er, lat);
        check("t3_size11_err", {31'd0, er}, 32'd1);
        check("t3_size11_rdata", rd, 32'd0);
        peek_check("t3_word_kept", 8'h0C, 32'h5555_AAAA);

        // 4: req_valid held high, address scrambled while busy
        req_valid = 1'b1; req_write = 1'b0;
        for (int n = 0; n < 4; n++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!req_ready && t < 50) begin @(negedge clk); t++; end
            check("t4_ready", {31'd0, req_ready}, 32'd1);
            req_write = 1'b0;
            req_size  = (n == 3) ? 2'b00 : 2'b10;
            req_addr  = (n == 3) ? 10'h023 : 10'(10'h010 * (n + 1));
            @(posedge clk); #1;
            acc[n] = cyc;
            req_addr = ADDR_W'($urandom); req_size = 2'($urandom); req_wdata = $urandom;
        end
        req_valid = 1'b0;
        for (int n = 1; n < 4; n++) check("t4_spacing", acc[n] - acc[n-1], WS + 3);
        repeat (WS + 3) @(negedge clk);

        // 5: reset on the access edge of a store
        req_write = 1'b1; req_size = 2'b10; req_addr = 10'h040; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("t5_ready", {31'd0, req_ready}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        peek_check("t5_peek", 8'h10, 32'd0);
        peek_check("t5_peek_cleared", 8'd4, 32'd0);
        repeat (WS + 3) begin
            @(negedge clk);
            check("t5_no_resp", {31'd0, resp_valid}, 32'd0);
        end

        // 6: zero-wait-state instance
        z_issue(1'b1, 2'b10, 10'h3FC, 32'hCAFE_F00D, rd, er, lat);
        check("t6_st_lat", lat, 32'd1);
        z_issue(1'b0, 2'b10, 10'h3FC, 32'd0, rd, er, lat);
        check("t6_ld_lat", lat, 32'd1);
        check("t6_ld_rdata", rd, 32'hCAFE_F00D);
        check("t6_ld_err", {31'd0, er}, 32'd0);
        #1 check("t6_peek", z_peek_data, 32'hCAFE_F00D);

        // Random traffic over a small region so lanes collide often
        for (int n = 0; n < 200; n++) begin
            peek_addr = ADDR_W-2'($urandom_range(0, 31));
            issue(1'($urandom), 2'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 127)),
                  $urandom, rd, er, lat);
            check("rnd_lat", lat, WS + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (WS + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
